// File: rtl/decode_ctrl.sv
// Registered decode stage between fetch and execute: turns an instruction word into
// datapath control with a one-entry valid/ready output register and halt-on-illegal.
module decode_ctrl #(
  parameter int CNT_W           = 8,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [2:0]       imm_sel,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             alu_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready never looks at in_valid; out_valid never looks at out_ready.
  typedef enum logic [1:0] {EMPTY, FULL, HALTED} state_t;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_U = 3'b011, IMM_J = 3'b100;

  state_t     state;
  logic       accept, drain, halt_now;
  logic [2:0] d_imm;
  logic       d_rw, d_mr, d_mw, d_br, d_jp, d_as, d_ill;
  logic [1:0] d_rs, d_aop;

  always_comb begin
    d_imm = IMM_I;
    d_rw  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_br  = 1'b0;
    d_jp  = 1'b0;
    d_as  = 1'b0;
    d_rs  = 2'b00;
    d_aop = 2'b00;
    d_ill = 1'b0;
    // Every legal opcode ends in 2'b11, so a non-32-bit encoding falls into default.
    case (in_instr[6:0])
      7'b0000011: begin d_rw = 1'b1; d_mr = 1'b1; d_as = 1'b1; d_rs = 2'b01; end
      7'b0010011: begin d_rw = 1'b1; d_as = 1'b1; d_aop = 2'b10; end
      7'b1100111: begin d_rw = 1'b1; d_jp = 1'b1; d_as = 1'b1; d_rs = 2'b10; end
      7'b0100011: begin d_imm = IMM_S; d_mw = 1'b1; d_as = 1'b1; end
      7'b1100011: begin d_imm = IMM_B; d_br = 1'b1; d_aop = 2'b01; end
      7'b0110111: begin d_imm = IMM_U; d_rw = 1'b1; d_as = 1'b1; d_aop = 2'b11; end
      7'b0010111: begin d_imm = IMM_U; d_rw = 1'b1; d_as = 1'b1; end
      7'b1101111: begin d_imm = IMM_J; d_rw = 1'b1; d_jp = 1'b1; d_rs = 2'b10; end
      7'b0110011: begin d_rw = 1'b1; d_aop = 2'b10; end
      default:    d_ill = 1'b1;
    endcase
  end

  assign drain    = (state == FULL) && out_ready;
  // Handing an illegal bundle to execute parks the block, so nothing may enter behind it.
  assign halt_now = (HALT_ON_ILLEGAL != 0) && drain && illegal;
  assign in_ready = !flush && (state != HALTED) && ((state == EMPTY) || out_ready) && !halt_now;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      out_valid     <= 1'b0;
      halted        <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      imm_sel       <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      alu_src       <= 1'b0;
      result_src    <= '0;
      alu_op        <= '0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        halted    <= 1'b0;
      end else if (halt_now) begin
        state     <= HALTED;
        out_valid <= 1'b0;
        halted    <= 1'b1;
      end else if (accept) begin
        state      <= FULL;
        out_valid  <= 1'b1;
        out_instr  <= in_instr;
        out_pc     <= in_pc;
        imm_sel    <= d_imm;
        reg_write  <= d_rw;
        mem_read   <= d_mr;
        mem_write  <= d_mw;
        branch     <= d_br;
        jump       <= d_jp;
        alu_src    <= d_as;
        result_src <= d_rs;
        alu_op     <= d_aop;
        illegal    <= d_ill;
      end else if (drain) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
      if (accept && d_ill && (illegal_count != {CNT_W{1'b1}}))
        illegal_count <= illegal_count + CNT_W'(1);
    end
  end

endmodule
